// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receive path.
// Stop-bit and parity codes match the values used by uart_tx.
package uart_rx_pkg;

  localparam int unsigned STOP_BITS_ONE      = 1;
  localparam int unsigned STOP_BITS_ONE_HALF = 2;
  localparam int unsigned STOP_BITS_TWO      = 3;

  localparam int unsigned PARITY_NONE = 1;
  localparam int unsigned PARITY_ODD  = 2;
  localparam int unsigned PARITY_EVEN = 3;

  // 2-of-3 vote used when majority sampling is built in
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// 2-FF synchroniser with falling-edge detect on the synchronised value.
// RESET_VAL sets the value all stages take in reset (1 for an idle-high line).
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_arst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_fall
);

  logic meta;
  logic sync_q;
  logic sync_prev;

  // Two-stage synchroniser plus one history stage for edge detection
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      meta      <= RESET_VAL;
      sync_q    <= RESET_VAL;
      sync_prev <= RESET_VAL;
    end else begin
      meta      <= i_async;
      sync_q    <= meta;
      sync_prev <= sync_q;
    end
  end

  assign o_sync = sync_q;
  assign o_fall = sync_prev & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start-bit validation, mid-bit sampling MSB first,
// optional parity, first stop bit checked, one-cycle o_valid pulse.
// Optional build macro UART_RX_MAJORITY_EN: each bit is the 2-of-3 vote
// around mid-bit, decided one cycle later.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned F_CLK      = 50_000_000,
  parameter int unsigned BAUDRATE   = 9600,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STOP_BITS  = STOP_BITS_ONE,
  parameter int unsigned PARITY     = PARITY_NONE
) (
  input  logic                  i_clk,
  input  logic                  i_arst_n,
  input  logic                  i_rx,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_parity_err,
  output logic                  o_frame_err,
  output logic                  o_busy
);

  localparam int unsigned BAUD_DIV   = F_CLK / BAUDRATE;
  localparam int unsigned HALF_DIV   = BAUD_DIV / 2;
  localparam int unsigned PAR_BITS   = (PARITY != PARITY_NONE) ? 1 : 0;
  localparam int unsigned FRAME_BITS = 1 + DATA_WIDTH + PAR_BITS + 1;
  localparam int unsigned CNT_W      = $clog2(BAUD_DIV);
  localparam int unsigned IDX_W      = $clog2(FRAME_BITS);

  if (BAUD_DIV < 4) begin : g_bad_baud
    $fatal(1, "uart_rx: BAUD_DIV must be at least 4");
  end
  if (STOP_BITS < 1 || STOP_BITS > 3) begin : g_bad_stop
    $fatal(1, "uart_rx: STOP_BITS code out of range");
  end
  if (PARITY < 1 || PARITY > 3) begin : g_bad_parity
    $fatal(1, "uart_rx: PARITY code out of range");
  end

  typedef enum logic [6:0] {
    S_IDLE   = 7'b0000001,
    S_START  = 7'b0000010,
    S_DATA   = 7'b0000100,
    S_PARITY = 7'b0001000,
    S_STOP   = 7'b0010000,
    S_DONE   = 7'b0100000,
    S_BREAK  = 7'b1000000
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [DATA_WIDTH-1:0]   sh;
  logic                    par_err;
  logic                    rx_s;
  logic                    rx_fall;
  logic                    bit_now;
  logic                    sample;

  uart_rx_sync #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .i_async  (i_rx),
    .o_sync   (rx_s),
    .o_fall   (rx_fall)
  );

`ifdef UART_RX_MAJORITY_EN
  // Majority mode samples one cycle later so the vote can include sample+1
  localparam int unsigned START_AT = HALF_DIV;
  logic rx_d1;
  logic rx_d2;

  // History of rx_s for the sample-1 / sample / sample+1 vote
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      rx_d1 <= 1'b1;
      rx_d2 <= 1'b1;
    end else begin
      rx_d1 <= rx_s;
      rx_d2 <= rx_d1;
    end
  end

  assign bit_now = maj3(rx_d2, rx_d1, rx_s);
`else
  localparam int unsigned START_AT = HALF_DIV - 1;

  assign bit_now = rx_s;
`endif

  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_AT);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BAUD_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_DATA  = IDX_W'(DATA_WIDTH);

  // Sample strobe: half a bit after t0 for the start bit, then every bit period
  always_comb begin
    sample = 1'b0;
    if (state == S_START) sample = (cnt == START_LAST);
    else                  sample = (cnt == BIT_LAST);
  end

  // Baud counter and frame bit index; both idle at zero outside a frame
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (state == S_IDLE || state == S_DONE || state == S_BREAK) begin
      cnt <= '0;
      idx <= '0;
    end else if (sample) begin
      cnt <= '0;
      idx <= idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Frame state machine with registered outputs
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state        <= S_IDLE;
      sh           <= '0;
      par_err      <= 1'b0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_fall) begin
            state   <= S_START;
            par_err <= 1'b0;
            o_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (sample) begin
            if (bit_now) begin
              state  <= S_IDLE;
              o_busy <= 1'b0;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (sample) begin
            sh <= DATA_WIDTH'({sh, bit_now});
            if (idx == LAST_DATA) state <= (PAR_BITS != 0) ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (sample) begin
            if (PARITY == PARITY_ODD) par_err <= (bit_now != ~^sh);
            else                      par_err <= (bit_now != ^sh);
            state <= S_STOP;
          end
        end
        S_STOP: begin
          if (sample) begin
            o_valid      <= 1'b1;
            o_data       <= sh;
            o_parity_err <= par_err;
            o_frame_err  <= ~bit_now;
            state        <= S_DONE;
          end
        end
        S_DONE: begin
          o_valid <= 1'b0;
          if (o_frame_err) begin
            state <= S_BREAK;
          end else begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end
        end
        S_BREAK: begin
          if (rx_s) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at BAUD_DIV=10: one instance without parity
// (one stop bit) and one with even parity (two stop bits). Frames are driven
// by the bench; received words are collected by monitors and compared with
// expectations computed from the frame contents.
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int D = 10;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         c;
  } rx_t;

  typedef struct {
    bit         sel;
    logic [7:0] d;
    bit         pbit;
    bit         stopv;
    logic [7:0] ed;
    bit         ep;
    bit         ef;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_n = 1'b1;
  logic rx_e = 1'b1;
  int   cyc = 0;

  logic [7:0] dn_data, de_data;
  logic dn_valid, dn_pe, dn_fe, dn_busy;
  logic de_valid, de_pe, de_fe, de_busy;

  int n_cmp = 0;
  int n_err = 0;

  rx_t qn[$];
  rx_t qe[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(
    .F_CLK(1_000_000), .BAUDRATE(100_000), .DATA_WIDTH(8),
    .STOP_BITS(STOP_BITS_ONE), .PARITY(PARITY_NONE)
  ) dut_n (
    .i_clk(clk), .i_arst_n(rst_n), .i_rx(rx_n),
    .o_data(dn_data), .o_valid(dn_valid), .o_parity_err(dn_pe),
    .o_frame_err(dn_fe), .o_busy(dn_busy)
  );

  uart_rx #(
    .F_CLK(1_000_000), .BAUDRATE(100_000), .DATA_WIDTH(8),
    .STOP_BITS(STOP_BITS_TWO), .PARITY(PARITY_EVEN)
  ) dut_e (
    .i_clk(clk), .i_arst_n(rst_n), .i_rx(rx_e),
    .o_data(de_data), .o_valid(de_valid), .o_parity_err(de_pe),
    .o_frame_err(de_fe), .o_busy(de_busy)
  );

  // Collect every received word with the cycle it was presented in
  always @(negedge clk) begin
    if (dn_valid) qn.push_back('{dn_data, dn_pe, dn_fe, cyc});
    if (de_valid) qe.push_back('{de_data, de_pe, de_fe, cyc});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int qsize(input bit sel);
    return sel ? qe.size() : qn.size();
  endfunction

  function automatic rx_t qat(input bit sel, input int i);
    return sel ? qe[i] : qn[i];
  endfunction

  // Reference: data is returned as sent; even parity is violated when the
  // total count of ones over data+parity is odd; a low stop bit is a frame error
  function automatic vec_t model(input bit sel, input logic [7:0] d, input bit pbit, input bit stopv);
    vec_t v;
    v.sel = sel; v.d = d; v.pbit = pbit; v.stopv = stopv;
    v.ed = d;
    v.ep = sel && ((($countones(d) + int'(pbit)) % 2) == 1);
    v.ef = !stopv;
    return v;
  endfunction

  // Cycles from driving the start edge to the o_valid cycle: 2 synchroniser
  // cycles to t0, then half a bit, the remaining bits and one S_DONE cycle
  function automatic int exp_lat(input bit sel);
    return 2 + D / 2 + (1 + 8 + (sel ? 1 : 0)) * D + 1 + MAJ;
  endfunction

  task automatic set_line(input bit sel, input logic v);
    if (sel) rx_e = v;
    else     rx_n = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame MSB first; glitch_k >= 0 inverts that bit for one cycle near mid-bit
  task automatic send(input bit sel, input logic [7:0] d, input bit pbit, input bit stopv,
                      input int glitch_k, output int start_c);
    logic [11:0] fb;
    int nb;
    fb = '1;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[1+i] = d[7-i];
    nb = 9;
    if (sel) begin fb[nb] = pbit; nb = nb + 1; end
    fb[nb] = stopv; nb = nb + 1;
    if (sel) begin fb[nb] = 1'b1; nb = nb + 1; end
    start_c = cyc;
    for (int k = 0; k < nb; k++) begin
      set_line(sel, fb[k]);
      if (k == glitch_k) begin
        idle(5);
        set_line(sel, ~fb[k]);
        idle(1);
        set_line(sel, fb[k]);
        idle(4);
      end else begin
        idle(D);
      end
    end
    set_line(sel, 1'b1);
  endtask

  initial begin
    vec_t vt[$];
    rx_t  r;
    int   base, sc;

    // Reset state
    idle(3);
    check("rst data", 32'(dn_data), 0);
    check("rst valid", 32'(dn_valid), 0);
    check("rst perr", 32'(dn_pe), 0);
    check("rst ferr", 32'(dn_fe), 0);
    check("rst busy", 32'(dn_busy), 0);
    check("rst busy_e", 32'(de_busy), 0);
    rst_n = 1'b1;
    idle(5);

    // Directed vectors followed by randomized ones
    vt.push_back('{1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0});
    vt.push_back('{1'b1, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0});
    vt.push_back('{1'b1, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0});
    vt.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1});
    vt.push_back('{1'b1, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0});
    vt.push_back('{1'b1, 8'h81, 1'b1, 1'b0, 8'h81, 1'b1, 1'b1});
    vt.push_back('{1'b0, 8'h01, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0});
    for (int i = 0; i < 16; i++)
      vt.push_back(model(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                         $urandom_range(0, 3) != 0));

    for (int i = 0; i < vt.size(); i++) begin
      base = qsize(vt[i].sel);
      send(vt[i].sel, vt[i].d, vt[i].pbit, vt[i].stopv, -1, sc);
      idle(15);
      check($sformatf("vec%0d count", i), 32'(qsize(vt[i].sel)), 32'(base + 1));
      if (qsize(vt[i].sel) > base) begin
        r = qat(vt[i].sel, base);
        check($sformatf("vec%0d data", i), 32'(r.d), 32'(vt[i].ed));
        check($sformatf("vec%0d perr", i), 32'(r.pe), 32'(vt[i].ep));
        check($sformatf("vec%0d ferr", i), 32'(r.fe), 32'(vt[i].ef));
        check($sformatf("vec%0d latency", i), 32'(r.c - sc), 32'(exp_lat(vt[i].sel)));
      end
      check($sformatf("vec%0d hold", i), 32'(vt[i].sel ? de_data : dn_data), 32'(vt[i].ed));
      check($sformatf("vec%0d busy", i), 32'(vt[i].sel ? de_busy : dn_busy), 0);
    end

    // Short low glitch: false start, busy for about half a bit
    base = qn.size();
    sc = cyc;
    rx_n = 1'b0;
    idle(3);
    rx_n = 1'b1;
    idle(1);
    check("glitch busy early", 32'(dn_busy), 1);
    idle(3);
    check("glitch busy mid", 32'(dn_busy), 1);
    idle(3);
    check("glitch busy back", 32'(dn_busy), 0);
    idle(120);
    check("glitch no valid", 32'(qn.size()), 32'(base));

    // Line held low for 20 bit times: one framing-error word, then recovery
    base = qn.size();
    rx_n = 1'b0;
    idle(20 * D);
    check("break count", 32'(qn.size()), 32'(base + 1));
    if (qn.size() > base) begin
      check("break data", 32'(qn[base].d), 0);
      check("break ferr", 32'(qn[base].fe), 1);
    end
    check("break busy", 32'(dn_busy), 1);
    rx_n = 1'b1;
    idle(20);
    check("break busy released", 32'(dn_busy), 0);
    send(1'b0, 8'h5A, 1'b0, 1'b1, -1, sc);
    idle(15);
    check("after break count", 32'(qn.size()), 32'(base + 2));
    if (qn.size() > base + 1) begin
      check("after break data", 32'(qn[base+1].d), 32'h5A);
      check("after break ferr", 32'(qn[base+1].fe), 0);
      check("after break perr", 32'(qn[base+1].pe), 0);
    end

    // Reset in the middle of 0x12, then a clean 0xFF
    base = qn.size();
    rx_n = 1'b0;
    idle(D);
    for (int i = 7; i >= 4; i--) begin
      rx_n = 1'(8'h12 >> i);
      idle(D);
    end
    rst_n = 1'b0;
    rx_n = 1'b1;
    idle(2);
    check("midrst busy", 32'(dn_busy), 0);
    check("midrst data", 32'(dn_data), 0);
    check("midrst valid", 32'(dn_valid), 0);
    rst_n = 1'b1;
    idle(30);
    check("midrst no valid", 32'(qn.size()), 32'(base));
    send(1'b0, 8'hFF, 1'b0, 1'b1, -1, sc);
    idle(15);
    check("midrst count", 32'(qn.size()), 32'(base + 1));
    if (qn.size() > base) begin
      check("midrst rx data", 32'(qn[base].d), 32'hFF);
      check("midrst rx ferr", 32'(qn[base].fe), 0);
    end

    // Back-to-back frames, even parity, two stop bits
    base = qe.size();
    send(1'b1, 8'h00, 1'b0, 1'b1, -1, sc);
    send(1'b1, 8'hFF, 1'b0, 1'b1, -1, sc);
    send(1'b1, 8'h81, 1'b0, 1'b1, -1, sc);
    idle(15);
    check("b2b count", 32'(qe.size()), 32'(base + 3));
    if (qe.size() >= base + 3) begin
      check("b2b data0", 32'(qe[base].d), 32'h00);
      check("b2b data1", 32'(qe[base+1].d), 32'hFF);
      check("b2b data2", 32'(qe[base+2].d), 32'h81);
      check("b2b errs", 32'({qe[base].pe, qe[base].fe, qe[base+1].pe, qe[base+1].fe,
                              qe[base+2].pe, qe[base+2].fe}), 0);
    end

`ifdef UART_RX_MAJORITY_EN
    // One-cycle glitch at mid-bit of data bit 3 (frame bit 5) is voted out
    base = qn.size();
    send(1'b0, 8'h55, 1'b0, 1'b1, 5, sc);
    idle(15);
    check("maj count", 32'(qn.size()), 32'(base + 1));
    if (qn.size() > base) check("maj data", 32'(qn[base].d), 32'h55);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
